front_panel_mem_ctrl: RTL and testbench
=======================================

Name: front_panel_mem_ctrl

Overview:
Front-panel initiator for the synchronous single-port RAM block. It turns Altair front-panel switch commands (EXAMINE, EXAMINE NEXT, DEPOSIT, DEPOSIT NEXT) into rd/we cycles on the RAM port. It arbitrates for the memory bus with the CPU through a req/grant handshake. It drives the address/data LED registers and reports completion.

Parameters:
ADDR_WIDTH, 16, RAM address width; also the width of the switch address and the panel address counter.
DATA_WIDTH, 8, RAM data width.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
reset_n  in  1  synchronous reset, active-low.
sw_addr  in  ADDR_WIDTH  address switches.
sw_data  in  DATA_WIDTH  data switches (low bits of the panel).
cmd_examine  in  1  one-cycle pulse.
cmd_examine_next  in  1  one-cycle pulse.
cmd_deposit  in  1  one-cycle pulse.
cmd_deposit_next  in  1  one-cycle pulse.
bus_req  out  1  request for the memory bus.
bus_grant  in  1  CPU has released the bus.
mem_addr  out  ADDR_WIDTH  RAM addr.
mem_wdata  out  DATA_WIDTH  RAM data_in.
mem_rd  out  1  RAM rd.
mem_we  out  1  RAM we.
mem_rdata  in  DATA_WIDTH  RAM data_out (registered in the RAM, 1-cycle latency).
addr_leds  out  ADDR_WIDTH  current panel address.
data_leds  out  DATA_WIDTH  last data read back.
busy  out  1  high whenever state is not IDLE.
done  out  1  one-cycle pulse when an operation completes.

Behaviour:
- All outputs are registered.
- On reset_n=0 at a rising edge:
  - state goes to IDLE.
  - bus_req, mem_rd, mem_we, busy, done are 0.
  - mem_addr, mem_wdata, addr_leds, data_leds are 0.
  - Reset applied mid-operation aborts it at once; no partial write is issued after the reset edge.
- Command acceptance:
  - Commands are sampled only in IDLE; pulses arriving while busy=1 are dropped.
  - Simultaneous pulses are resolved by fixed priority: examine > examine_next > deposit > deposit_next.
- Address selection on acceptance:
  - examine / deposit: addr_leds <= sw_addr.
  - *_next: addr_leds <= addr_leds + 1, modulo 2^ADDR_WIDTH (all-ones wraps to 0).
  - sw_data is captured into mem_wdata at the same edge.
- States:
  - IDLE: on an accepted command -> ARB, with bus_req<=1 and busy<=1.
  - ARB: holds until bus_grant=1 is sampled. Then -> WR (deposit kinds, mem_we<=1) or RD (examine kinds, mem_rd<=1). mem_addr<=addr_leds.
  - WR: mem_we<=0, mem_rd<=1 -> RD. This reads back the written byte; the RAM updates the cell at this edge.
  - RD: mem_rd<=0 -> RD_WAIT. The RAM registers data_out at this edge.
  - RD_WAIT: data_leds<=mem_rdata, bus_req<=0, done<=1, busy<=0 -> IDLE.
- done is high for exactly one cycle: the cycle after leaving RD_WAIT.
- mem_we and mem_rd are never high together, and each is high for exactly one cycle per operation.
- Latency with bus_grant held at 1, counting from the accepting edge E0:
  - examine: data_leds valid and done high after E3.
  - deposit: data_leds valid and done high after E4.
- bus_grant is ignored outside ARB. Deassertion after the grant does not abort the operation; the CPU must hold the grant until bus_req falls.
- A new command may be accepted in the cycle done is high (state is IDLE).

Decomposition:
- Shared package front_panel_pkg holds:
  - the state enum: IDLE, ARB, WR, RD, RD_WAIT;
  - the command-kind enum: EXAMINE, EXAMINE_NEXT, DEPOSIT, DEPOSIT_NEXT;
  - the priority encoding as a constant function.
- No sub-module is required; the FSM and datapath stay in one module.
- The bench instantiates the existing RAM model as the memory.

Test Plan:
- Examine with grant=1: RAM preloaded with 0x3C at address 0x0100; sw_addr=0x0100, pulse cmd_examine -> mem_rd high one cycle, data_leds=0x3C and done=1 after E3, addr_leds=0x0100, bus_req low afterwards.
- Deposit then examine_next: sw_addr=0x0010, sw_data=0xA5, deposit -> RAM[0x0010]=0xA5 and data_leds=0xA5 after E4. Then examine_next -> addr_leds=0x0011 and data_leds=RAM[0x0011].
- Grant stall: bus_grant=0 for 10 cycles after the command -> bus_req=1, busy=1, mem_rd/mem_we stay 0. Raise grant -> the operation completes 3 cycles after grant is sampled (examine).
- Wrap and priority: addr_leds=0xFFFF, pulse deposit_next and examine together -> examine wins with addr=sw_addr. Separately, deposit_next from 0xFFFF -> write at 0x0000.
- Busy drop: pulse cmd_deposit while in ARB -> ignored; exactly one mem_we pulse is seen in total.
- Reset mid-op: reset_n=0 in the WR state -> after that edge, mem_we=0 and all outputs are 0; no write occurs to the target address on later cycles.

Source files
------------

// File: rtl/front_panel_pkg.sv
// Shared types for the front-panel memory initiator: FSM states, command kinds
// and the fixed-priority command encoder.
package front_panel_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARB     = 3'd1,
        WR      = 3'd2,
        RD      = 3'd3,
        RD_WAIT = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        EXAMINE      = 2'd0,
        EXAMINE_NEXT = 2'd1,
        DEPOSIT      = 2'd2,
        DEPOSIT_NEXT = 2'd3
    } cmd_kind_t;

    typedef struct packed {
        logic      valid;
        cmd_kind_t kind;
    } cmd_sel_t;

    // Simultaneous pulses resolve as examine > examine_next > deposit > deposit_next.
    function automatic cmd_sel_t encode_cmd(
        input logic ex,
        input logic ex_next,
        input logic dep,
        input logic dep_next
    );
        cmd_sel_t sel;
        sel.valid = ex | ex_next | dep | dep_next;
        if (ex)            sel.kind = EXAMINE;
        else if (ex_next)  sel.kind = EXAMINE_NEXT;
        else if (dep)      sel.kind = DEPOSIT;
        else               sel.kind = DEPOSIT_NEXT;
        return sel;
    endfunction

    function automatic logic is_deposit(input cmd_kind_t kind);
        return (kind == DEPOSIT) || (kind == DEPOSIT_NEXT);
    endfunction

    function automatic logic is_next(input cmd_kind_t kind);
        return (kind == EXAMINE_NEXT) || (kind == DEPOSIT_NEXT);
    endfunction

endpackage

// File: rtl/front_panel_mem_ctrl.sv
// Altair front-panel initiator: converts switch commands into read/write cycles
// on a single-port synchronous RAM after winning the bus from the CPU.
module front_panel_mem_ctrl
    import front_panel_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] sw_addr,
    input  logic [DATA_WIDTH-1:0] sw_data,
    input  logic                  cmd_examine,
    input  logic                  cmd_examine_next,
    input  logic                  cmd_deposit,
    input  logic                  cmd_deposit_next,
    output logic                  bus_req,
    input  logic                  bus_grant,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_rd,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [ADDR_WIDTH-1:0] addr_leds,
    output logic [DATA_WIDTH-1:0] data_leds,
    output logic                  busy,
    output logic                  done
);

    state_t                r_state;
    cmd_kind_t             r_kind;
    logic                  r_bus_req;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_mem_rd;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_addr_leds;
    logic [DATA_WIDTH-1:0] r_data_leds;
    logic                  r_busy;
    logic                  r_done;

    cmd_sel_t              w_cmd;
    logic [ADDR_WIDTH-1:0] w_addr_inc;

    always_comb begin
        w_cmd      = encode_cmd(cmd_examine, cmd_examine_next, cmd_deposit, cmd_deposit_next);
        w_addr_inc = r_addr_leds + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_kind      <= EXAMINE;
            r_bus_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_rd    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_addr_leds <= '0;
            r_data_leds <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_cmd.valid) begin
                        r_kind      <= w_cmd.kind;
                        r_addr_leds <= is_next(w_cmd.kind) ? w_addr_inc : sw_addr;
                        r_mem_wdata <= sw_data;
                        r_bus_req   <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ARB;
                    end
                end
                ARB: begin
                    if (bus_grant) begin
                        r_mem_addr <= r_addr_leds;
                        if (is_deposit(r_kind)) begin
                            r_mem_we <= 1'b1;
                            r_state  <= WR;
                        end else begin
                            r_mem_rd <= 1'b1;
                            r_state  <= RD;
                        end
                    end
                end
                // Deposits read the cell back so the data LEDs show what landed in RAM.
                WR: begin
                    r_mem_we <= 1'b0;
                    r_mem_rd <= 1'b1;
                    r_state  <= RD;
                end
                RD: begin
                    r_mem_rd <= 1'b0;
                    r_state  <= RD_WAIT;
                end
                RD_WAIT: begin
                    r_data_leds <= mem_rdata;
                    r_bus_req   <= 1'b0;
                    r_done      <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
                default: begin
                    r_mem_rd  <= 1'b0;
                    r_mem_we  <= 1'b0;
                    r_bus_req <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign bus_req   = r_bus_req;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_rd    = r_mem_rd;
    assign mem_we    = r_mem_we;
    assign addr_leds = r_addr_leds;
    assign data_leds = r_data_leds;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_front_panel_mem_ctrl.sv
// Directed bench for front_panel_mem_ctrl with a behavioural RAM and a
// transaction-level reference model of panel address, data and memory contents.
module tb_front_panel_mem_ctrl;

    localparam int AW = 16;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] sw_addr;
    logic [DW-1:0] sw_data;
    logic          cmd_examine, cmd_examine_next, cmd_deposit, cmd_deposit_next;
    logic          bus_req, bus_grant;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rd, mem_we;
    logic [DW-1:0] mem_rdata;
    logic [AW-1:0] addr_leds;
    logic [DW-1:0] data_leds;
    logic          busy, done;

    always #5 clk = ~clk;

    front_panel_mem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset_n(reset_n),
        .sw_addr(sw_addr), .sw_data(sw_data),
        .cmd_examine(cmd_examine), .cmd_examine_next(cmd_examine_next),
        .cmd_deposit(cmd_deposit), .cmd_deposit_next(cmd_deposit_next),
        .bus_req(bus_req), .bus_grant(bus_grant),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rd(mem_rd), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .addr_leds(addr_leds), .data_leds(data_leds),
        .busy(busy), .done(done)
    );

    // Synchronous RAM with registered read data.
    logic [DW-1:0] ram [0:65535];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= ram[mem_addr];
    end

    // Reference model state.
    logic [DW-1:0] ref_mem [0:65535];
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    bit            outstanding = 1'b1;
    int            n_we = 0;
    int            n_rd = 0;
    int            errors = 0;
    int            checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".bus_req"},   32'(bus_req),   0);
        check({tag, ".mem_rd"},    32'(mem_rd),    0);
        check({tag, ".mem_we"},    32'(mem_we),    0);
        check({tag, ".busy"},      32'(busy),      0);
        check({tag, ".done"},      32'(done),      0);
        check({tag, ".mem_addr"},  32'(mem_addr),  0);
        check({tag, ".mem_wdata"}, 32'(mem_wdata), 0);
        check({tag, ".addr_leds"}, 32'(addr_leds), 0);
        check({tag, ".data_leds"}, 32'(data_leds), 0);
    endtask

    // Per-cycle compare: strobe exclusivity always; LEDs against the model while idle.
    always @(negedge clk) begin
        if (reset_n) begin
            check("rd_we_exclusive", 32'(mem_rd & mem_we), 0);
            if (mem_we) n_we++;
            if (mem_rd) n_rd++;
            if (!outstanding && !busy) begin
                check("idle.addr_leds", 32'(addr_leds), 32'(m_addr));
                check("idle.data_leds", 32'(data_leds), 32'(m_data));
                check("idle.bus_req",   32'(bus_req),   0);
            end
        end
    end

    // cmds = {examine, examine_next, deposit, deposit_next}
    task automatic run_op(input string tag, input logic [3:0] cmds, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input int grant_delay, input bit inject_drop);
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        bit dep, nxt, got;
        int lat, exp_lat, we0, rd0;

        if (cmds[3])      begin dep = 0; nxt = 0; end
        else if (cmds[2]) begin dep = 0; nxt = 1; end
        else if (cmds[1]) begin dep = 1; nxt = 0; end
        else              begin dep = 1; nxt = 1; end
        ea      = nxt ? m_addr + 16'd1 : a;
        ed      = dep ? d : ref_mem[ea];
        exp_lat = grant_delay + (dep ? 4 : 3);
        we0 = n_we;
        rd0 = n_rd;

        outstanding = 1'b1;
        sw_addr = a;
        sw_data = d;
        {cmd_examine, cmd_examine_next, cmd_deposit, cmd_deposit_next} = cmds;
        if (grant_delay > 0) bus_grant = 1'b0;
        @(posedge clk); #1;
        {cmd_examine, cmd_examine_next, cmd_deposit, cmd_deposit_next} = 4'b0000;
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < grant_delay; i++) begin
            check({tag, ".stall_req"},    32'(bus_req), 1);
            check({tag, ".stall_busy"},   32'(busy), 1);
            check({tag, ".stall_strobe"}, 32'(mem_rd | mem_we), 0);
            if (inject_drop && i == 0) cmd_deposit = 1'b1;
            @(posedge clk); #1;
            cmd_deposit = 1'b0;
            lat++;
        end
        bus_grant = 1'b1;
        while (!got && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (done) got = 1'b1;
        end
        check({tag, ".done_seen"}, 32'(got), 1);
        check({tag, ".latency"},   32'(lat), 32'(exp_lat));
        check({tag, ".addr_leds"}, 32'(addr_leds), 32'(ea));
        check({tag, ".data_leds"}, 32'(data_leds), 32'(ed));
        check({tag, ".bus_req"},   32'(bus_req), 0);
        check({tag, ".busy"},      32'(busy), 0);
        check({tag, ".we_pulses"}, 32'(n_we - we0), 32'(dep));
        check({tag, ".rd_pulses"}, 32'(n_rd - rd0), 1);
        if (dep) begin
            ref_mem[ea] = d;
            check({tag, ".ram_cell"}, 32'(ram[ea]), 32'(d));
        end
        m_addr = ea;
        m_data = ed;
        outstanding = 1'b0;
        $display("op %-24s addr=%04h data=%02h latency=%0d", tag, addr_leds, data_leds, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] cell_after;
        int we0;

        for (int i = 0; i < 65536; i++) begin
            ram[i]     = 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
            ref_mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
        end
        ram[16'h0100]     = 8'h3C;
        ref_mem[16'h0100] = 8'h3C;

        reset_n = 1'b0;
        bus_grant = 1'b1;
        sw_addr = '0;
        sw_data = '0;
        {cmd_examine, cmd_examine_next, cmd_deposit, cmd_deposit_next} = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;
        m_addr = '0;
        m_data = '0;
        outstanding = 1'b0;
        $display("op %-24s all outputs cleared", "reset");
        @(posedge clk); #1;

        run_op("examine", 4'b1000, 16'h0100, 8'h00, 0, 0);
        check("lit.examine_data", 32'(data_leds), 32'h3C);
        check("lit.examine_addr", 32'(addr_leds), 32'h0100);

        run_op("deposit", 4'b0010, 16'h0010, 8'hA5, 0, 0);
        check("lit.deposit_data", 32'(data_leds), 32'hA5);
        check("lit.deposit_ram",  32'(ram[16'h0010]), 32'hA5);

        run_op("examine_next", 4'b0100, 16'h1234, 8'h00, 0, 0);
        check("lit.exnext_addr", 32'(addr_leds), 32'h0011);
        check("lit.exnext_data", 32'(data_leds), 32'h4B);

        run_op("examine_grant_stall", 4'b1000, 16'h0100, 8'h00, 10, 0);

        run_op("examine_ffff", 4'b1000, 16'hFFFF, 8'h00, 0, 0);
        run_op("priority_ex_over_depnext", 4'b1001, 16'h0200, 8'h77, 0, 0);
        check("lit.prio_addr", 32'(addr_leds), 32'h0200);

        run_op("examine_ffff_again", 4'b1000, 16'hFFFF, 8'h00, 0, 0);
        run_op("deposit_next_wrap", 4'b0001, 16'h5555, 8'hC3, 0, 0);
        check("lit.wrap_addr", 32'(addr_leds), 32'h0000);
        check("lit.wrap_ram",  32'(ram[16'h0000]), 32'hC3);

        run_op("deposit_busy_drop", 4'b0010, 16'h0040, 8'h99, 3, 1);

        // Reset while the write strobe is up.
        outstanding = 1'b1;
        sw_addr = 16'h0080;
        sw_data = 8'hEE;
        bus_grant = 1'b1;
        cmd_deposit = 1'b1;
        @(posedge clk); #1;
        cmd_deposit = 1'b0;
        @(posedge clk); #1;
        check("rst_mid.in_wr", 32'(mem_we), 1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        check_all_zero("rst_mid");
        reset_n = 1'b1;
        m_addr = '0;
        m_data = '0;
        outstanding = 1'b0;
        we0 = n_we;
        cell_after = ram[16'h0080];
        repeat (10) @(posedge clk);
        #1;
        check("rst_mid.no_later_we", 32'(n_we - we0), 0);
        check("rst_mid.cell_stable", 32'(ram[16'h0080]), 32'(cell_after));
        $display("op %-24s aborted in WR, outputs cleared", "reset_mid_op");

        run_op("post_reset_examine_next", 4'b0100, 16'hABCD, 8'h00, 0, 0);
        check("lit.post_reset_addr", 32'(addr_leds), 32'h0001);
        check("lit.post_reset_data", 32'(data_leds), 32'h5B);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
